// File: rtl/keypad_if.sv
// Keypad pin and key-event bundle: rows/cols face the matrix, key_* face the game logic.
// master = scanner side, slave = keypad/consumer side.
interface keypad_if #(
    parameter int NROWS  = 4,
    parameter int NCOLS  = 4,
    parameter int CODE_W = $clog2(NROWS * NCOLS)
);
    logic [NROWS-1:0]  rows;
    logic [NCOLS-1:0]  cols;
    logic [CODE_W-1:0] key_code;
    logic              key_valid;
    logic              key_press;
    logic              key_release;

    modport master (
        input  rows,
        output cols, key_code, key_valid, key_press, key_release
    );

    modport slave (
        output rows,
        input  cols, key_code, key_valid, key_press, key_release
    );
endinterface

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner with frame-based debounce and press/release strobes.
// Define KEYPAD_REPEAT_EN to build the auto-repeat of key_press while a key is held.
module keypad_scanner #(
    parameter int NROWS        = 4,
    parameter int NCOLS        = 4,
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE     = 4,
    parameter int REPEAT_DELAY = 30,
    parameter int REPEAT_RATE  = 8
) (
    input  logic     clk,
    input  logic     rst,
    keypad_if.master kp
);
    localparam int CODE_W = $clog2(NROWS * NCOLS);
    localparam int DIV_W  = $clog2(SCAN_DIV);
    localparam int COL_W  = $clog2(NCOLS);
    localparam int CNT_W  = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} state_t;

    logic [DIV_W-1:0]  div_q;
    logic [COL_W-1:0]  col_q;
    logic              step, frame_end;
    logic              row_hit;
    logic [CODE_W-1:0] row_code;
    logic              frame_hit_q;
    logic [CODE_W-1:0] frame_code_q;
    logic              ev_hit;
    logic [CODE_W-1:0] ev_code;
    logic              match_key;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CODE_W-1:0] cand_q, cand_d;

    logic              do_accept, do_release, do_repeat;
    logic [CODE_W-1:0] accept_code;

    logic [CODE_W-1:0] key_code_q;
    logic              key_valid_q, key_press_q, key_release_q;

    // ---------------- column scan ----------------
    assign step      = (div_q == DIV_W'(SCAN_DIV - 1));
    assign frame_end = step && (col_q == COL_W'(NCOLS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
            col_q <= '0;
        end else if (step) begin
            div_q <= '0;
            col_q <= frame_end ? '0 : col_q + COL_W'(1);
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

    assign kp.cols = ~(NCOLS'(1) << col_q);

    // Lowest low row wins within a column; descending loop leaves the lowest index last.
    always_comb begin
        row_hit  = 1'b0;
        row_code = '0;
        for (int r = NROWS - 1; r >= 0; r--) begin
            if (!kp.rows[r]) begin
                row_hit  = 1'b1;
                row_code = CODE_W'(r * NCOLS + int'(col_q));
            end
        end
    end

    // ---------------- per-frame first-hit capture ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_hit_q  <= 1'b0;
            frame_code_q <= '0;
        end else if (frame_end) begin
            frame_hit_q  <= 1'b0;
            frame_code_q <= '0;
        end else if (step && row_hit && !frame_hit_q) begin
            frame_hit_q  <= 1'b1;
            frame_code_q <= row_code;
        end
    end

    // The last column's sample is folded in directly so the FSM sees it at the wrap.
    assign ev_hit    = frame_hit_q || row_hit;
    assign ev_code   = frame_hit_q ? frame_code_q : row_code;
    assign match_key = ev_hit && (ev_code == key_code_q);

    // ---------------- debounce FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cand_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
        end
    end

    // ---------------- debounce FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        if (frame_end) begin
            case (state_q)
                IDLE: begin
                    if (ev_hit) begin
                        cand_d  = ev_code;
                        cnt_d   = CNT_W'(1);
                        state_d = (DEBOUNCE == 1) ? HELD : PRESS_DB;
                    end
                end
                PRESS_DB: begin
                    if (ev_hit && ev_code == cand_q) begin
                        if (cnt_q == CNT_W'(DEBOUNCE - 1)) state_d = HELD;
                        else                               cnt_d   = cnt_q + CNT_W'(1);
                    end else begin
                        state_d = IDLE;
                    end
                end
                HELD: begin
                    if (!match_key) begin
                        cnt_d   = CNT_W'(1);
                        state_d = (DEBOUNCE == 1) ? IDLE : REL_DB;
                    end
                end
                REL_DB: begin
                    if (match_key)                          state_d = HELD;
                    else if (cnt_q == CNT_W'(DEBOUNCE - 1)) state_d = IDLE;
                    else                                    cnt_d   = cnt_q + CNT_W'(1);
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // ---------------- debounce FSM: output decode ----------------
    always_comb begin
        do_accept   = frame_end && (state_d == HELD) &&
                      (state_q == IDLE || state_q == PRESS_DB);
        do_release  = frame_end && (state_d == IDLE) &&
                      (state_q == HELD || state_q == REL_DB);
        accept_code = (state_q == IDLE) ? ev_code : cand_q;
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    logic [RPT_W-1:0] rpt_q, rpt_thr;
    logic             rpt_first_q, held_stay;

    // Counts held frames since the last pulse; only advances while staying in HELD.
    assign held_stay = frame_end && (state_q == HELD) && (state_d == HELD);
    assign rpt_thr   = rpt_first_q ? RPT_W'(REPEAT_DELAY) : RPT_W'(REPEAT_RATE);
    assign do_repeat = held_stay && (rpt_q + RPT_W'(1) == rpt_thr);

    always_ff @(posedge clk) begin
        if (rst || do_accept || do_release) begin
            rpt_q       <= '0;
            rpt_first_q <= 1'b1;
        end else if (held_stay) begin
            if (do_repeat) begin
                rpt_q       <= '0;
                rpt_first_q <= 1'b0;
            end else begin
                rpt_q <= rpt_q + RPT_W'(1);
            end
        end
    end
`else
    assign do_repeat = 1'b0;
`endif

    // ---------------- registered outputs ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            key_code_q    <= '0;
            key_valid_q   <= 1'b0;
            key_press_q   <= 1'b0;
            key_release_q <= 1'b0;
        end else begin
            key_press_q   <= do_accept || do_repeat;
            key_release_q <= do_release;
            if (do_accept) begin
                key_code_q  <= accept_code;
                key_valid_q <= 1'b1;
            end else if (do_release) begin
                key_valid_q <= 1'b0;
            end
        end
    end

    assign kp.key_code    = key_code_q;
    assign kp.key_valid   = key_valid_q;
    assign kp.key_press   = key_press_q;
    assign kp.key_release = key_release_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: directed scenarios plus random key frames
// checked against a frame-level run-length model of the debounce rules.
module tb_keypad_scanner;
    localparam int NR = 4, NC = 4, SD = 4, DB = 2, RD = 3, RR = 2;
    localparam int FRAME = NC * SD;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pressed;

    always #5 clk = ~clk;

    keypad_if #(.NROWS(NR), .NCOLS(NC)) kp ();

    keypad_scanner #(
        .NROWS(NR), .NCOLS(NC), .SCAN_DIV(SD), .DEBOUNCE(DB),
        .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kp)
    );

    // A pressed key shorts its row to its column while that column is driven low.
    always_comb begin
        kp.rows = '1;
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++)
                if (pressed[r*NC+c] && !kp.cols[c]) kp.rows[r] = 1'b0;
    end

    int n_pass = 0, n_total = 0;
    int press_total = 0;
    int m_valid, m_code, run, run_code, miss, held_n;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_valid = 0; m_code = 0; run = 0; run_code = 0; miss = 0; held_n = 0;
    endtask

    // One frame of the reference: winner = first pressed key in column-major order,
    // then run-length rules for accept / release / repeat.
    task automatic model_frame(input logic [15:0] p, output int ep, output int er);
        int hit = 0, code = 0;
        ep = 0; er = 0;
        for (int c = 0; c < NC; c++)
            for (int r = 0; r < NR; r++)
                if (hit == 0 && p[r*NC+c]) begin hit = 1; code = r * NC + c; end
        if (m_valid == 0) begin
            if (hit == 0) run = 0;
            else if (run > 0 && code != run_code) run = 0;
            else begin
                if (run == 0) run_code = code;
                run++;
            end
            if (run >= DB) begin
                m_valid = 1; m_code = run_code; run = 0; held_n = 0; ep = 1;
            end
        end else if (hit != 0 && code == m_code) begin
            if (miss > 0) miss = 0;
            else begin
                held_n++;
`ifdef KEYPAD_REPEAT_EN
                if (held_n == RD || (held_n > RD && (held_n - RD) % RR == 0)) ep = 1;
`endif
            end
        end else begin
            miss++;
            if (miss >= DB) begin m_valid = 0; miss = 0; er = 1; end
        end
    endtask

    // Starts at a negedge just before a frame's first posedge, ends at the negedge after its end.
    task automatic run_frame(input logic [15:0] p);
        int np = 0, nr = 0, ep, er;
        logic [3:0] ecols;
        pressed = p;
        for (int i = 1; i <= FRAME; i++) begin
            @(posedge clk);
            @(negedge clk);
            ecols = ~(4'b0001 << ((i / SD) % NC));
            check("cols", kp.cols, ecols);
            if (kp.key_press)   np++;
            if (kp.key_release) nr++;
            if (kp.key_press && kp.key_release) check("press_and_release", 1, 0);
        end
        press_total += np;
        model_frame(p, ep, er);
        check("press_cnt", np, ep);
        check("release_cnt", nr, er);
        check("key_valid", kp.key_valid, m_valid);
        check("key_code", kp.key_code, m_code);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pressed = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_cols", kp.cols, 4'b1110);
        check("rst_code", kp.key_code, 0);
        check("rst_valid", kp.key_valid, 0);
        check("rst_press", kp.key_press, 0);
        check("rst_release", kp.key_release, 0);
        rst = 1'b0;
        model_reset();
    endtask

    localparam logic [15:0] K6 = 16'h0040;   // r1c2
    localparam logic [15:0] K5 = 16'h0020;   // r1c1

    initial begin
        int t6_start, exp_rep;
        logic [15:0] p;
        pressed = '0;
        rst = 1'b1;
        @(negedge clk);
        do_reset();

        // idle scanning
        run_frame('0);
        run_frame('0);

        // clean press of key 6 held three frames
        run_frame(K6);
        run_frame(K6);
        check("t2_code", kp.key_code, 6);
        check("t2_valid", kp.key_valid, 1);
        run_frame(K6);

        // release: key_code stays
        run_frame('0);
        run_frame('0);
        check("t4_valid", kp.key_valid, 0);
        check("t4_code", kp.key_code, 6);

        // one-frame bounce is ignored
        run_frame(K6);
        run_frame('0);
        run_frame('0);
        check("t3_valid", kp.key_valid, 0);

        // r0c3 + r2c1 together: column 1 wins
        run_frame(16'h0208);
        run_frame(16'h0208);
        check("t5_code", kp.key_code, 9);

        // reset mid-hold: outputs clear, no release pulse
        repeat (5) begin @(posedge clk); @(negedge clk); end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_valid", kp.key_valid, 0);
        check("midrst_code", kp.key_code, 0);
        check("midrst_release", kp.key_release, 0);
        check("midrst_cols", kp.cols, 4'b1110);
        pressed = '0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_release2", kp.key_release, 0);
        rst = 1'b0;
        model_reset();

        // long hold: repeat pulses only when the feature is built
        t6_start = press_total;
        repeat (10) run_frame(K5);
`ifdef KEYPAD_REPEAT_EN
        exp_rep = 4;
`else
        exp_rep = 1;
`endif
        check("t6_press_total", press_total - t6_start, exp_rep);
        repeat (3) run_frame('0);

        // random frames: mostly held runs with glitches, gaps and multi-key frames
        p = '0;
        for (int i = 0; i < 40; i++) begin
            int mode;
            mode = $urandom_range(0, 9);
            if (mode == 5 || mode == 6) p = 16'(1) << $urandom_range(0, 15);
            else if (mode == 7)         p = '0;
            else if (mode == 8)         p = (16'(1) << $urandom_range(0, 15)) |
                                            (16'(1) << $urandom_range(0, 15));
            else if (mode == 9)         p = p | (16'(1) << $urandom_range(0, 15));
            run_frame(p);
        end
        repeat (3) run_frame('0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule
